// File: rtl/spi_sample_responder_pkg.sv
// Shared definitions for the SPI sample responder: default frame geometry
// and the FSM state encoding used by the responder and the SPI peripheral.
package spi_sample_responder_pkg;

   localparam int SPI_FRAME_BITS = 16;
   localparam int SPI_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } spi_state_e;

endpackage

// File: rtl/spi_tx_fifo.sv
// Transmit sample FIFO. Head word is visible combinationally so the frame
// start can load it in the same cycle it is popped. DEPTH must be a power
// of two (>= 2) so the pointers wrap naturally.
module spi_tx_fifo
   import spi_sample_responder_pkg::*;
#(
   parameter int WIDTH = SPI_FRAME_BITS,
   parameter int DEPTH = SPI_FIFO_DEPTH
)(
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_push_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_head,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_full    = (r_level == LW'(DEPTH));
   assign o_empty   = (r_level == {LW{1'b0}});
   assign o_level   = r_level;
   assign o_head    = r_mem[r_rd_ptr];

   // A pop from an empty FIFO is ignored; a push into a full FIFO is only
   // accepted when a real pop frees a slot in the same cycle.
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   // Storage, pointer and occupancy update.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_level  <= {LW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/spi_sample_responder.sv
// SPI mode-0 slave that streams queued samples out on SDO and captures
// the master's SDI word. All pins are synchronised into the Clk domain;
// the FSM acts on edges of the synchronised signals.
module spi_sample_responder
   import spi_sample_responder_pkg::*;
#(
   parameter int FRAME_BITS = SPI_FRAME_BITS,
   parameter int FIFO_DEPTH = SPI_FIFO_DEPTH
)(
   input  logic                          Clk,
   input  logic                          Reset_,
   input  logic                          SCK,
   input  logic                          CS,
   input  logic                          SDI,
   output logic                          SDO,
   output logic                          SDOEn,
   input  logic [FRAME_BITS-1:0]         TxData,
   input  logic                          TxPush,
   output logic                          TxFull,
   output logic [$clog2(FIFO_DEPTH):0]   TxLevel,
   output logic [FRAME_BITS-1:0]         RxData,
   output logic                          RxValid,
   output logic                          Underrun,
   output logic                          FrameErr
);

   localparam int              CW       = $clog2(FRAME_BITS) + 1;
   localparam logic [CW-1:0]   LAST_BIT = CW'(FRAME_BITS - 1);

   // Synchronisers and edge-detect history
   logic r_sck_meta, r_sck_sync, r_sck_prev;
   logic r_cs_meta,  r_cs_sync,  r_cs_prev;
   logic r_sdi_meta, r_sdi_sync;

   // CS must be seen high after reset before a fall may start a frame
   logic [1:0] r_flush;
   logic       r_cs_armed;

   // FSM and datapath
   spi_state_e              r_state;
   logic [CW-1:0]           r_bit_cnt;
   logic [FRAME_BITS-2:0]   r_tx_shift;   // bits still to send after SDO
   logic [FRAME_BITS-2:0]   r_rx_shift;   // bits received so far
   logic [FRAME_BITS-1:0]   r_rx_data;
   logic                    r_sdo;
   logic                    r_sdo_en;
   logic                    r_rx_valid;
   logic                    r_underrun;
   logic                    r_frame_err;

   logic                    w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
   logic                    w_pop;
   logic [FRAME_BITS-1:0]   w_fifo_head;
   logic                    w_fifo_empty;
   logic [FRAME_BITS-1:0]   w_rx_next;

   assign w_sck_rise = r_sck_sync & ~r_sck_prev;
   assign w_sck_fall = ~r_sck_sync & r_sck_prev;
   assign w_cs_fall  = r_cs_prev & ~r_cs_sync & r_cs_armed;
   assign w_cs_rise  = ~r_cs_prev & r_cs_sync;
   assign w_pop      = (r_state == ST_IDLE) & w_cs_fall;
   assign w_rx_next  = {r_rx_shift, r_sdi_sync};

   assign SDO      = r_sdo;
   assign SDOEn    = r_sdo_en;
   assign RxData   = r_rx_data;
   assign RxValid  = r_rx_valid;
   assign Underrun = r_underrun;
   assign FrameErr = r_frame_err;

   spi_tx_fifo #(
      .WIDTH (FRAME_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .i_clk       (Clk),
      .i_rst_n     (Reset_),
      .i_push      (TxPush),
      .i_push_data (TxData),
      .i_pop       (w_pop),
      .o_head      (w_fifo_head),
      .o_full      (TxFull),
      .o_empty     (w_fifo_empty),
      .o_level     (TxLevel)
   );

   // Two-flop synchronisers plus one history flop for edge detection.
   always_ff @(posedge Clk) begin
      if (!Reset_) begin
         r_sck_meta <= 1'b0;
         r_sck_sync <= 1'b0;
         r_sck_prev <= 1'b0;
         r_cs_meta  <= 1'b1;
         r_cs_sync  <= 1'b1;
         r_cs_prev  <= 1'b1;
         r_sdi_meta <= 1'b0;
         r_sdi_sync <= 1'b0;
      end else begin
         r_sck_meta <= SCK;
         r_sck_sync <= r_sck_meta;
         r_sck_prev <= r_sck_sync;
         r_cs_meta  <= CS;
         r_cs_sync  <= r_cs_meta;
         r_cs_prev  <= r_cs_sync;
         r_sdi_meta <= SDI;
         r_sdi_sync <= r_sdi_meta;
      end
   end

   // Arm frame start only once the synchronised CS reflects the pin and is high,
   // so a CS held low through reset cannot masquerade as a fresh fall.
   always_ff @(posedge Clk) begin
      if (!Reset_) begin
         r_flush    <= 2'd0;
         r_cs_armed <= 1'b0;
      end else begin
         if (r_flush != 2'd2) begin
            r_flush <= r_flush + 2'd1;
         end else begin
            r_flush <= r_flush;
         end
         if ((r_flush == 2'd2) && r_cs_sync) begin
            r_cs_armed <= 1'b1;
         end else begin
            r_cs_armed <= r_cs_armed;
         end
      end
   end

   // Frame FSM with shift registers and registered pin/status outputs.
   always_ff @(posedge Clk) begin
      if (!Reset_) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= {CW{1'b0}};
         r_tx_shift  <= {(FRAME_BITS-1){1'b0}};
         r_rx_shift  <= {(FRAME_BITS-1){1'b0}};
         r_rx_data   <= {FRAME_BITS{1'b0}};
         r_sdo       <= 1'b0;
         r_sdo_en    <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_underrun  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_valid  <= 1'b0;
         r_underrun  <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_sdo    <= 1'b0;
               r_sdo_en <= 1'b0;
               if (w_cs_fall) begin
                  r_state    <= ST_SHIFT;
                  r_sdo_en   <= 1'b1;
                  r_bit_cnt  <= {CW{1'b0}};
                  r_rx_shift <= {(FRAME_BITS-1){1'b0}};
                  if (w_fifo_empty) begin
                     // Frame still runs, sending zeros.
                     r_tx_shift <= {(FRAME_BITS-1){1'b0}};
                     r_sdo      <= 1'b0;
                     r_underrun <= 1'b1;
                  end else begin
                     r_tx_shift <= w_fifo_head[FRAME_BITS-2:0];
                     r_sdo      <= w_fifo_head[FRAME_BITS-1];
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               if (w_cs_rise) begin
                  // Short frame: drop it, RxData keeps its old word.
                  r_state     <= ST_IDLE;
                  r_sdo       <= 1'b0;
                  r_sdo_en    <= 1'b0;
                  r_frame_err <= 1'b1;
               end else if (w_sck_rise) begin
                  r_rx_shift <= w_rx_next[FRAME_BITS-2:0];
                  r_bit_cnt  <= r_bit_cnt + CW'(1);
                  if (r_bit_cnt == LAST_BIT) begin
                     r_rx_data  <= w_rx_next;
                     r_rx_valid <= 1'b1;
                     r_sdo      <= 1'b0;
                     r_state    <= ST_HOLD;
                  end else begin
                     r_state <= ST_SHIFT;
                  end
               end else if (w_sck_fall) begin
                  r_sdo      <= r_tx_shift[FRAME_BITS-2];
                  r_tx_shift <= {r_tx_shift[FRAME_BITS-3:0], 1'b0};
               end else begin
                  r_state <= ST_SHIFT;
               end
            end
            ST_HOLD: begin
               r_sdo <= 1'b0;
               if (w_cs_rise) begin
                  r_state  <= ST_IDLE;
                  r_sdo_en <= 1'b0;
               end else begin
                  r_state <= ST_HOLD;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_sdo    <= 1'b0;
               r_sdo_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_sample_responder.sv
// Self-checking bench: table of frames plus hand-written corner sequences.
// Expected receive words go into a scoreboard queue when a frame is driven
// and are popped when the DUT pulses RxValid.
module tb_spi_sample_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sck, cs, sdi, sdo, sdo_en;
   logic [15:0] tx_data;
   logic        tx_push, tx_full;
   logic [2:0]  tx_level;
   logic [15:0] rx_data;
   logic        rx_valid, underrun, frame_err;

   spi_sample_responder dut (
      .Clk      (clk),
      .Reset_   (rst_n),
      .SCK      (sck),
      .CS       (cs),
      .SDI      (sdi),
      .SDO      (sdo),
      .SDOEn    (sdo_en),
      .TxData   (tx_data),
      .TxPush   (tx_push),
      .TxFull   (tx_full),
      .TxLevel  (tx_level),
      .RxData   (rx_data),
      .RxValid  (rx_valid),
      .Underrun (underrun),
      .FrameErr (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        push;
      logic [15:0] tx;
      logic [15:0] sdi;
      logic [15:0] exp_sdo;
      logic        exp_ur;
   } vec_t;

   vec_t        vecs [5];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] exp_q [$];

   // Pulse monitor, sampled on the falling edge
   int          mon_rx_cnt = 0;
   int          mon_ur_cnt = 0;
   int          mon_fe_cnt = 0;
   logic [15:0] mon_rx_last = 16'h0000;

   always @(negedge clk) begin
      if (rx_valid) begin
         mon_rx_cnt  <= mon_rx_cnt + 1;
         mon_rx_last <= rx_data;
      end
      if (underrun)  mon_ur_cnt <= mon_ur_cnt + 1;
      if (frame_err) mon_fe_cnt <= mon_fe_cnt + 1;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_word(input logic [15:0] w);
      tx_data = w;
      tx_push = 1'b1;
      tick(1);
      tx_push = 1'b0;
   endtask

   // Master side of one frame with 8-Clk SCK phases; CS rises after nbits.
   task automatic run_frame(input logic [15:0] sdi_word, input int nbits,
                            input logic co_push, input logic [15:0] co_word,
                            output logic [15:0] sdo_word);
      sdo_word = 16'h0000;
      if (nbits == 16) exp_q.push_back(sdi_word);
      cs = 1'b0;
      tick(2);
      check("sdoen_before_latency", {31'd0, sdo_en}, 32'd0);
      if (co_push) begin
         tx_data = co_word;
         tx_push = 1'b1;
      end
      tick(1);
      tx_push = 1'b0;
      check("sdoen_after_latency", {31'd0, sdo_en}, 32'd1);
      tick(5);
      for (int i = 0; i < nbits; i++) begin
         sdi = sdi_word[15-i];
         tick(8);
         sdo_word[15-i] = sdo;
         sck = 1'b1;
         tick(8);
         sck = 1'b0;
      end
      tick(8);
      cs = 1'b1;
      tick(8);
   endtask

   task automatic frame_and_check(input string name, input logic [15:0] sdi_word,
                                  input logic [15:0] exp_sdo, input int exp_ur,
                                  input logic co_push, input logic [15:0] co_word);
      int          rx0, ur0, fe0;
      logic [15:0] got_sdo;
      rx0 = mon_rx_cnt;
      ur0 = mon_ur_cnt;
      fe0 = mon_fe_cnt;
      run_frame(sdi_word, 16, co_push, co_word, got_sdo);
      check({name, "_sdo"}, {16'd0, got_sdo}, {16'd0, exp_sdo});
      check({name, "_rxvalid_pulses"}, mon_rx_cnt - rx0, 32'd1);
      check({name, "_underrun_pulses"}, mon_ur_cnt - ur0, exp_ur);
      check({name, "_frameerr_pulses"}, mon_fe_cnt - fe0, 32'd0);
      check({name, "_rxdata_port"}, {16'd0, rx_data}, {16'd0, sdi_word});
      if ((mon_rx_cnt != rx0) && (exp_q.size() > 0)) begin
         check({name, "_scoreboard"}, {16'd0, mon_rx_last}, {16'd0, exp_q.pop_front()});
      end
      check({name, "_sdoen_idle"}, {31'd0, sdo_en}, 32'd0);
   endtask

   initial begin
      int          rx0, ur0, fe0;
      logic [15:0] prev_rx, dummy;

      vecs[0] = '{1'b1, 16'hA5C3, 16'h3C5A, 16'hA5C3, 1'b0};
      vecs[1] = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000, 1'b1};
      vecs[2] = '{1'b1, 16'h8001, 16'h0001, 16'h8001, 1'b0};
      vecs[3] = '{1'b1, 16'h0000, 16'h8000, 16'h0000, 1'b0};
      vecs[4] = '{1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0};

      rst_n = 1'b0; cs = 1'b1; sck = 1'b0; sdi = 1'b0;
      tx_data = 16'h0000; tx_push = 1'b0;
      tick(4);
      check("reset_sdo",    {31'd0, sdo},      32'd0);
      check("reset_sdoen",  {31'd0, sdo_en},   32'd0);
      check("reset_level",  {29'd0, tx_level}, 32'd0);
      check("reset_full",   {31'd0, tx_full},  32'd0);
      check("reset_rxdata", {16'd0, rx_data},  32'd0);
      check("reset_pulses", {29'd0, rx_valid, underrun, frame_err}, 32'd0);
      rst_n = 1'b1;
      tick(4);

      // Table-driven single frames
      for (int v = 0; v < 5; v++) begin
         if (vecs[v].push) push_word(vecs[v].tx);
         check("vec_level_before", {29'd0, tx_level}, {31'd0, vecs[v].push});
         frame_and_check("vec", vecs[v].sdi, vecs[v].exp_sdo, {31'd0, vecs[v].exp_ur}, 1'b0, 16'h0000);
         check("vec_level_after", {29'd0, tx_level}, 32'd0);
      end

      // Overfill: fifth push dropped, four frames drain in order, fifth underruns
      for (int w = 1; w <= 5; w++) push_word(16'(w));
      check("fill_full",  {31'd0, tx_full},  32'd1);
      check("fill_level", {29'd0, tx_level}, 32'd4);
      for (int k = 0; k < 4; k++) begin
         frame_and_check("drain", 16'h1000 + 16'(k), 16'(k + 1), 0, 1'b0, 16'h0000);
      end
      frame_and_check("drain_empty", 16'h2222, 16'h0000, 1, 1'b0, 16'h0000);

      // Short frame: 9 rises then CS rises
      push_word(16'h0F0F);
      prev_rx = rx_data;
      rx0 = mon_rx_cnt; fe0 = mon_fe_cnt;
      run_frame(16'h1234, 9, 1'b0, 16'h0000, dummy);
      check("short_frameerr", mon_fe_cnt - fe0, 32'd1);
      check("short_no_rxvalid", mon_rx_cnt - rx0, 32'd0);
      check("short_rxdata_kept", {16'd0, rx_data}, {16'd0, prev_rx});
      check("short_idle_sdoen", {31'd0, sdo_en}, 32'd0);
      check("short_word_discarded", {29'd0, tx_level}, 32'd0);
      frame_and_check("after_short", 16'h4321, 16'h0000, 1, 1'b0, 16'h0000);

      // Full FIFO with push coinciding with the frame-start pop
      for (int w = 0; w < 4; w++) push_word(16'h0010 + 16'(w));
      check("copush_full_before", {29'd0, tx_level}, 32'd4);
      frame_and_check("copush_f0", 16'h0A0A, 16'h0010, 0, 1'b1, 16'h0014);
      check("copush_level", {29'd0, tx_level}, 32'd4);
      frame_and_check("copush_f1", 16'h0B0B, 16'h0011, 0, 1'b0, 16'h0000);
      frame_and_check("copush_f2", 16'h0C0C, 16'h0012, 0, 1'b0, 16'h0000);
      frame_and_check("copush_f3", 16'h0D0D, 16'h0013, 0, 1'b0, 16'h0000);
      frame_and_check("copush_f4", 16'h0E0E, 16'h0014, 0, 1'b0, 16'h0000);
      check("copush_level_end", {29'd0, tx_level}, 32'd0);

      // Reset pulse during bit 7 of a frame, CS held low across it
      push_word(16'hBEEF);
      cs = 1'b0;
      tick(16);
      for (int i = 0; i < 7; i++) begin
         sdi = 1'b1;
         tick(8);
         sck = 1'b1;
         tick(8);
         sck = 1'b0;
      end
      tick(2);
      check("midreset_active", {31'd0, sdo_en}, 32'd1);
      rx0 = mon_rx_cnt; ur0 = mon_ur_cnt; fe0 = mon_fe_cnt;
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check("midreset_outputs", {sdo, sdo_en, tx_full, tx_level, rx_valid, underrun, frame_err},
            32'd0);
      check("midreset_rxdata", {16'd0, rx_data}, 32'd0);
      tick(10);
      check("midreset_no_start", {31'd0, sdo_en}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         tick(8);
         sck = 1'b1;
         tick(8);
         sck = 1'b0;
      end
      check("midreset_still_idle", {31'd0, sdo_en}, 32'd0);
      check("midreset_no_pulses", (mon_rx_cnt - rx0) + (mon_ur_cnt - ur0) + (mon_fe_cnt - fe0),
            32'd0);
      cs = 1'b1;
      tick(8);
      push_word(16'h7E81);
      frame_and_check("post_reset", 16'h5AA5, 16'h7E81, 0, 1'b0, 16'h0000);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
